flow_target_rx: RTL and testbench

Target-side receive flow: the responder counterpart of the controller write flow. Consumes byte-level bus events from the target PHY/bus FSM, filters on the target's own static address and packs write-payload bytes little-endian into 32-bit dwords for the target RX queue. On every STOP or repeated START it flushes any partial dword and emits one response descriptor (status, TID, byte count) into the target response queue.

---
 rtl/i3c_pkg.sv | 25 ++
 rtl/flow_target_rx.sv | 168 ++++++++++++++++
 tb/tb_flow_target_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_pkg.sv
// Shared types for the target receive flow: FSM states, response
// descriptor layout and error codes.
package i3c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_IGNORE,
    ST_RECV,
    ST_PUSH,
    ST_FLUSH,
    ST_RESP
  } target_rx_state_e;

  typedef struct packed {
    logic [3:0]  err;
    logic [3:0]  tid;
    logic [7:0]  rsvd;
    logic [15:0] byte_cnt;
  } target_resp_desc_t;

  localparam logic [3:0] ErrSuccess = 4'h0;
  localparam logic [3:0] ErrOvl     = 4'h6;

endpackage

// File: rtl/flow_target_rx.sv
// Target receive flow: address filter, LE dword packing, response descriptors.
// Ports: bus events in, byte handshake, RX/resp queue write ports, idle_o.
module flow_target_rx
  import i3c_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxBytes  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [6:0]           target_addr_i,
  input  logic                 enable_i,
  input  logic                 bus_start_i,
  input  logic                 bus_stop_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  input  logic [7:0]           byte_i,
  output logic                 addr_match_o,
  output logic                 rx_queue_wvalid_o,
  input  logic                 rx_queue_wready_i,
  output logic [DataWidth-1:0] rx_queue_wdata_o,
  output logic                 resp_queue_wvalid_o,
  input  logic                 resp_queue_wready_i,
  output logic [31:0]          resp_queue_wdata_o,
  output logic                 idle_o
);

  target_rx_state_e r_state, w_state_d;

  logic [7:0]  r_lane [4];
  logic [15:0] r_byte_cnt;
  logic        r_ovl;
  logic [3:0]  r_tid;
  logic        r_pend_evt;
  logic        r_pend_start;
  logic        r_addr_match;

  logic w_acc;
  logic w_match;
  logic w_full;
  logic w_store;
  logic w_last;
  logic w_part;
  logic w_evt;

  target_resp_desc_t w_desc;

  assign w_acc   = byte_valid_i & byte_ready_o;
  assign w_match = (byte_i[7:1] == target_addr_i) & ~byte_i[0];
  assign w_full  = (r_byte_cnt == 16'(MaxBytes));
  assign w_store = (r_state == ST_RECV) & w_acc & ~w_full;
  assign w_last  = w_store & (r_byte_cnt[1:0] == 2'd3);
  // a stored non-last byte always leaves a partial word behind
  assign w_part  = w_store | (r_byte_cnt[1:0] != 2'd0);
  assign w_evt   = bus_start_i | bus_stop_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d           = r_state;
    byte_ready_o        = 1'b0;
    rx_queue_wvalid_o   = 1'b0;
    resp_queue_wvalid_o = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus_start_i & enable_i) w_state_d = ST_ADDR;
      end
      ST_ADDR: begin
        byte_ready_o = 1'b1;
        if (bus_stop_i) w_state_d = ST_IDLE;
        else if (w_acc) w_state_d = w_match ? ST_RECV : ST_IGNORE;
      end
      ST_IGNORE: begin
        byte_ready_o = 1'b1;
        if (bus_stop_i) w_state_d = ST_IDLE;
        else if (bus_start_i) w_state_d = ST_ADDR;
      end
      ST_RECV: begin
        byte_ready_o = 1'b1;
        // byte is stored first; an event in the same cycle is latched
        if (w_last) w_state_d = ST_PUSH;
        else if (w_evt) w_state_d = w_part ? ST_FLUSH : ST_RESP;
      end
      ST_PUSH: begin
        rx_queue_wvalid_o = 1'b1;
        if (rx_queue_wready_i)
          w_state_d = (r_pend_evt | w_evt) ? ST_RESP : ST_RECV;
      end
      ST_FLUSH: begin
        rx_queue_wvalid_o = 1'b1;
        if (rx_queue_wready_i) w_state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_queue_wvalid_o = 1'b1;
        if (resp_queue_wready_i)
          w_state_d = ((r_pend_start | bus_start_i) & enable_i)
                    ? ST_ADDR : ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) r_lane[i] <= 8'h00;
      r_byte_cnt   <= '0;
      r_ovl        <= 1'b0;
      r_tid        <= '0;
      r_pend_evt   <= 1'b0;
      r_pend_start <= 1'b0;
      r_addr_match <= 1'b0;
    end else begin
      r_addr_match <= (r_state == ST_ADDR) & w_acc & w_match & ~bus_stop_i;
      unique case (r_state)
        ST_ADDR: begin
          if (w_acc & w_match) begin
            for (int i = 0; i < 4; i++) r_lane[i] <= 8'h00;
            r_byte_cnt   <= '0;
            r_ovl        <= 1'b0;
            r_pend_evt   <= 1'b0;
            r_pend_start <= 1'b0;
          end
        end
        ST_RECV, ST_PUSH, ST_FLUSH: begin
          if (w_store) begin
            r_lane[r_byte_cnt[1:0]] <= byte_i;
            r_byte_cnt              <= r_byte_cnt + 16'd1;
          end
          if ((r_state == ST_RECV) & w_acc & w_full) r_ovl <= 1'b1;
          if (w_evt) r_pend_evt <= 1'b1;
          if (bus_start_i) r_pend_start <= 1'b1;
          else if (bus_stop_i) r_pend_start <= 1'b0;
          if ((r_state != ST_RECV) & rx_queue_wready_i)
            for (int i = 0; i < 4; i++) r_lane[i] <= 8'h00;
        end
        ST_RESP: begin
          if (bus_start_i) r_pend_start <= 1'b1;
          if (resp_queue_wready_i) begin
            r_tid        <= r_tid + 4'd1;
            r_pend_evt   <= 1'b0;
            r_pend_start <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_desc          = '0;
    w_desc.err      = r_ovl ? ErrOvl : ErrSuccess;
    w_desc.tid      = r_tid;
    w_desc.byte_cnt = r_byte_cnt;
  end

  assign rx_queue_wdata_o   = DataWidth'({r_lane[3], r_lane[2],
                                          r_lane[1], r_lane[0]});
  assign resp_queue_wdata_o = w_desc;
  assign addr_match_o       = r_addr_match;
  assign idle_o             = (r_state == ST_IDLE);

endmodule

// File: tb/tb_flow_target_rx.sv
// Scoreboard bench for flow_target_rx: expected RX words and descriptors
// are queued by each scenario and checked by monitors on every handshake.
module tb_flow_target_rx;

  localparam int MAXB = 8;
  localparam logic [6:0] TADDR = 7'h2D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        bus_start, bus_stop;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_d;
  logic        addr_match;
  logic        rx_wvalid, rx_wready;
  logic [31:0] rx_wdata;
  logic        resp_wvalid, resp_wready;
  logic [31:0] resp_wdata;
  logic        idle;

  int n_vec = 0;
  int n_err = 0;
  int n_am  = 0;
  int exp_tid = 0;

  logic [31:0] rx_q[$];
  logic [31:0] resp_q[$];

  flow_target_rx #(.DataWidth(32), .MaxBytes(MAXB)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .target_addr_i       (TADDR),
    .enable_i            (enable),
    .bus_start_i         (bus_start),
    .bus_stop_i          (bus_stop),
    .byte_valid_i        (byte_valid),
    .byte_ready_o        (byte_ready),
    .byte_i              (byte_d),
    .addr_match_o        (addr_match),
    .rx_queue_wvalid_o   (rx_wvalid),
    .rx_queue_wready_i   (rx_wready),
    .rx_queue_wdata_o    (rx_wdata),
    .resp_queue_wvalid_o (resp_wvalid),
    .resp_queue_wready_i (resp_wready),
    .resp_queue_wdata_o  (resp_wdata),
    .idle_o              (idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && addr_match) n_am++;
    if (rst_n && rx_wvalid && rx_wready) begin
      logic [31:0] e;
      n_vec++;
      if (rx_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected got=%08h want=none", rx_wdata);
      end else begin
        e = rx_q.pop_front();
        if (rx_wdata !== e) begin
          n_err++;
          $display("FAIL rx_word got=%08h want=%08h", rx_wdata, e);
        end
      end
    end
    if (rst_n && resp_wvalid && resp_wready) begin
      logic [31:0] e;
      n_vec++;
      if (resp_q.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected got=%08h want=none", resp_wdata);
      end else begin
        e = resp_q.pop_front();
        if (resp_wdata !== e) begin
          n_err++;
          $display("FAIL resp_desc got=%08h want=%08h", resp_wdata, e);
        end
      end
    end
  end

  function automatic logic [31:0] desc(input logic [3:0] err,
                                       input int len);
    logic [3:0] t;
    t = 4'(exp_tid);
    exp_tid = exp_tid + 1;
    return {err, t, 8'h00, 16'(len)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus_start = 1'b1;
    tick();
    bus_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus_stop = 1'b1;
    tick();
    bus_stop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_d = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout got=ready0 want=ready1");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while ((!idle || rx_q.size() != 0 || resp_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (!idle || rx_q.size() != 0 || resp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain got=idle%0b rxq%0d respq%0d want=idle1 empty",
               name, idle, rx_q.size(), resp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (idle !== 1'b1) begin
      n_err++; $display("FAIL rst_idle got=%b want=1", idle);
    end
    n_vec++;
    if (rx_wvalid !== 1'b0 || resp_wvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid got=%b%b want=00", rx_wvalid, resp_wvalid);
    end
    n_vec++;
    if (addr_match !== 1'b0 || byte_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_misc got=%b%b want=00", addr_match, byte_ready);
    end
    tick();
  endtask

  task automatic test_write();
    int am0;
    am0 = n_am;
    rx_q.push_back(32'h44332211);
    rx_q.push_back(32'h00000055);
    resp_q.push_back(desc(4'h0, 5));
    pulse_start();
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    pulse_stop();
    wait_idle("write");
    n_vec++;
    if (n_am - am0 != 1) begin
      n_err++; $display("FAIL write_am got=%0d want=1", n_am - am0);
    end
  endtask

  task automatic test_nomatch();
    int am0;
    logic [7:0] addrs [2];
    addrs[0] = 8'h5B;
    addrs[1] = 8'h40;
    am0 = n_am;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      send_byte(addrs[i]);
      send_byte(8'hA1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      pulse_stop();
      wait_idle("nomatch");
    end
    n_vec++;
    if (n_am != am0) begin
      n_err++; $display("FAIL nomatch_am got=%0d want=0", n_am - am0);
    end
  endtask

  task automatic test_overflow();
    rx_q.push_back(32'h04030201);
    rx_q.push_back(32'h08070605);
    resp_q.push_back(desc(4'h6, MAXB));
    pulse_start();
    send_byte(8'h5A);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    pulse_stop();
    wait_idle("ovl");
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    rx_wready = 1'b0;
    rx_q.push_back(32'hDDCCBBAA);
    rx_q.push_back(32'h000000EE);
    resp_q.push_back(desc(4'h0, 5));
    pulse_start();
    send_byte(8'h5A);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    byte_d = 8'hEE;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (byte_ready !== 1'b0 || rx_wvalid !== 1'b1 ||
          rx_wdata !== 32'hDDCCBBAA) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold got=%0d_bad_cycles want=0", bad);
    end
    tick();
    rx_wready = 1'b1;
    send_byte(8'hEE);
    pulse_stop();
    wait_idle("stall");
  endtask

  task automatic zero_xfer(input logic chk_lat);
    resp_q.push_back(desc(4'h0, 0));
    pulse_start();
    send_byte(8'h5A);
    pulse_stop();
    if (chk_lat) begin
      @(negedge clk);
      n_vec++;
      if (resp_wvalid !== 1'b1 || rx_wvalid !== 1'b0) begin
        n_err++;
        $display("FAIL stop_latency got=%b%b want=10", resp_wvalid, rx_wvalid);
      end
    end
    wait_idle("zero");
  endtask

  task automatic test_rstart_wrap();
    rx_q.push_back(32'h0000BBAA);
    resp_q.push_back(desc(4'h0, 2));
    resp_q.push_back(desc(4'h0, 1));
    rx_q.push_back(32'h000000CC);
    pulse_start();
    send_byte(8'h5A);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start();
    send_byte(8'h5A);
    send_byte(8'hCC);
    pulse_stop();
    wait_idle("rstart");
    zero_xfer(1'b1);
    for (int i = 0; i < 14; i++) zero_xfer(1'b0);
  endtask

  task automatic test_enable();
    enable = 1'b0;
    pulse_start();
    @(negedge clk);
    n_vec++;
    if (idle !== 1'b1) begin
      n_err++; $display("FAIL enable_idle got=%b want=1", idle);
    end
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    rx_wready = 1'b0;
    pulse_start();
    send_byte(8'h5A);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    @(negedge clk);
    n_vec++;
    if (rx_wvalid !== 1'b1) begin
      n_err++; $display("FAIL mid_push got=%b want=1", rx_wvalid);
    end
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (rx_wvalid !== 1'b0 || resp_wvalid !== 1'b0 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset got=%b%b%b want=001",
               rx_wvalid, resp_wvalid, idle);
    end
    rst_n = 1'b1;
    rx_wready = 1'b1;
    exp_tid = 0;
    tick();
    zero_xfer(1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    bus_start   = 1'b0;
    bus_stop    = 1'b0;
    byte_valid  = 1'b0;
    byte_d      = 8'h00;
    rx_wready   = 1'b1;
    resp_wready = 1'b1;
    test_reset();
    test_write();
    test_nomatch();
    test_overflow();
    test_stall();
    test_rstart_wrap();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
